// File: rtl/store_buffer_if.sv
// Pipeline/memory-side signal bundle for the posted-write store buffer.
// The slave modport is the buffer itself; master is the pipeline/memory environment.
interface store_buffer_if #(
  parameter int unsigned PTR_W = 2
);
  logic             st_valid;
  logic             st_ready;
  logic [11:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_size;
  logic             ld_valid;
  logic [11:0]      ld_addr;
  logic             ld_stall;
  logic [11:0]      dm_addr;
  logic [31:0]      dm_din;
  logic             dm_wr;
  logic [1:0]       dm_swsrc;
  logic             empty;
  logic [PTR_W:0]   count;

  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr,
    input  st_ready, ld_stall, dm_addr, dm_din, dm_wr, dm_swsrc, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr,
    output st_ready, ld_stall, dm_addr, dm_din, dm_wr, dm_swsrc, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM and dm_4k: retires one store per cycle through the
// shared memory port, yielding to non-overlapping loads and stalling overlapping ones.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic full;
  logic hit;
  logic push;
  logic pop;

  // Word-granular overlap against entries resident at the start of the cycle
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ent_q[i].addr[11:2] == bus.ld_addr[11:2])) hit = 1'b1;
    end
  end

  // Handshake, arbitration and memory-port mux
  always_comb begin
    full         = (count_q == FULL_CNT);
    push         = bus.st_valid && !full;
    pop          = !(bus.ld_valid && !hit) && (count_q != '0);
    bus.st_ready = !full;
    bus.empty    = (count_q == '0);
    bus.count    = count_q;
    bus.ld_stall = bus.ld_valid && hit;
    bus.dm_addr  = bus.ld_addr;
    bus.dm_din   = 32'd0;
    bus.dm_wr    = 1'b0;
    bus.dm_swsrc = 2'b00;
    if (pop) begin
      bus.dm_addr  = ent_q[head_q].addr;
      bus.dm_din   = ent_q[head_q].data;
      bus.dm_swsrc = ent_q[head_q].size;
      bus.dm_wr    = 1'b1;
    end
  end

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q]   <= '{addr: bus.st_addr, data: bus.st_data, size: bus.st_size};
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
